// File: rtl/irq_request_latch_if.sv
// irq_request_latch_if: request/snapshot/ack bundle for irq_request_latch.
//   slave  - the latch: takes req_in/mask/ack/ack_id, drives the rest.
//   master - the producer/consumer side (encoder + servicing logic).
// Signals:
//   req_in   raw request lines            mask      1 = hide line from snapshot
//   pend_out snapshot to encoder input    irq_valid snapshot non-zero, awaiting ack
//   ack      one-cycle service pulse      ack_id    id being serviced
//   pending  live pending register        drop_cnt  saturating lost-event count
//   bad_ack  sticky, ack id not in snapshot
interface irq_request_latch_if #(
  parameter int WIDTH = 8,
  parameter int ID_W  = 3,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] req_in;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] pend_out;
  logic             irq_valid;
  logic             ack;
  logic [ID_W-1:0]  ack_id;
  logic [WIDTH-1:0] pending;
  logic [CNT_W-1:0] drop_cnt;
  logic             bad_ack;

  modport slave (
    input  req_in, mask, ack, ack_id,
    output pend_out, irq_valid, pending, drop_cnt, bad_ack
  );

  modport master (
    output req_in, mask, ack, ack_id,
    input  pend_out, irq_valid, pending, drop_cnt, bad_ack
  );
endinterface

// File: rtl/irq_request_latch.sv
// irq_request_latch: front end of the 8:3 priority encoder.
//   Latches request events into a pending register, presents a frozen masked
//   snapshot to the encoder under irq_valid, and clears only the bit the
//   consumer acks. Acks naming a bit outside the snapshot set sticky bad_ack.
// Ports:
//   clk  - single clock, posedge
//   rst  - synchronous, active-high reset
//   bus  - irq_request_latch_if.slave (req_in, mask, ack, ack_id in;
//          pend_out, irq_valid, pending, drop_cnt, bad_ack out)
// Build option:
//   IRQ_EDGE_DETECT_EN - defined: rising-edge events plus drop counter.
//                        undefined: level events, drop_cnt tied to 0.
module irq_request_latch #(
  parameter int WIDTH = 8,
  parameter int ID_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  irq_request_latch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ASSERT, CLEAR} state_t;

  state_t           state;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] snapshot;
  logic [WIDTH-1:0] pend_q;
  logic             valid_q;
  logic             bad_q;
  logic [CNT_W-1:0] drop_q;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] visible;
  logic             ack_hit;

`ifdef IRQ_EDGE_DETECT_EN
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic [WIDTH-1:0] req_q;
  int               drop_inc;
  int               drop_sum;

  assign ev = bus.req_in & ~req_q;

  // An event landing on an already-pending line is lost; count it.
  always_comb begin
    drop_inc = 0;
    for (int i = 0; i < WIDTH; i++)
      drop_inc += int'(ev[i] & pending_q[i]);
    drop_sum = int'(drop_q) + drop_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= '0;
      drop_q <= '0;
    end else begin
      req_q  <= bus.req_in;
      drop_q <= (drop_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(drop_sum);
    end
  end
`else
  assign ev     = bus.req_in;
  assign drop_q = '0;
`endif

  assign visible = pending_q & ~bus.mask;

  // Out-of-range ids short-circuit before the snapshot index.
  assign ack_hit = (int'(bus.ack_id) < WIDTH) && snapshot[bus.ack_id];

  always_comb begin
    clr_vec = '0;
    if (state == ASSERT && bus.ack && ack_hit)
      clr_vec[bus.ack_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending_q <= '0;
      snapshot  <= '0;
      pend_q    <= '0;
      valid_q   <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      // OR-ing ev after the clear lets a same-cycle event survive its ack.
      pending_q <= (pending_q & ~clr_vec) | ev;
      case (state)
        IDLE: begin
          // Snapshot from registered pending only; this cycle's ev waits.
          if (|visible) begin
            snapshot <= visible;
            pend_q   <= visible;
            valid_q  <= 1'b1;
            state    <= ASSERT;
          end
        end
        ASSERT: begin
          if (bus.ack) begin
            if (ack_hit) begin
              pend_q  <= '0;
              valid_q <= 1'b0;
              state   <= CLEAR;
            end else begin
              bad_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          snapshot <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pend_out  = pend_q;
  assign bus.irq_valid = valid_q;
  assign bus.pending   = pending_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.bad_ack   = bad_q;

endmodule

// File: tb/tb_irq_request_latch.sv
module tb_irq_request_latch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_request_latch_if #(.WIDTH(8), .ID_W(3), .CNT_W(8)) bus ();

  irq_request_latch #(.WIDTH(8), .ID_W(3), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference: pending set, shown snapshot (0 = none), a gap counter
  // covering the dead cycle after a good ack, lost-event count, sticky flag.
  logic [7:0] mp, mshow, mreq_q;
  bit         mvalid, mbad;
  int         mgap, mdrop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] m,
                            input logic a, input logic [2:0] id);
    logic [7:0] ev, clr;
    int pc;
    if (rst) begin
      mp = 0; mshow = 0; mreq_q = 0; mvalid = 0; mbad = 0; mgap = 0; mdrop = 0;
      return;
    end
`ifdef IRQ_EDGE_DETECT_EN
    ev = r & ~mreq_q;
`else
    ev = r;
`endif
    mreq_q = r;
    clr = 0;
    if (mvalid) begin
      if (a) begin
        if (mshow[id]) begin
          clr[id] = 1'b1; mvalid = 0; mshow = 0; mgap = 1;
        end else mbad = 1;
      end
    end else if (mgap > 0) begin
      mgap--;
    end else if ((mp & ~m) != 0) begin
      mshow = mp & ~m; mvalid = 1;
    end
`ifdef IRQ_EDGE_DETECT_EN
    pc = $countones(ev & mp);
    mdrop = (mdrop + pc > 255) ? 255 : mdrop + pc;
`else
    pc = 0;
`endif
    mp = (mp & ~clr) | ev;
  endtask

  task automatic cycle(input logic [7:0] r, input logic [7:0] m,
                       input logic a, input logic [2:0] id);
    bus.req_in = r; bus.mask = m; bus.ack = a; bus.ack_id = id;
    @(posedge clk);
    model_step(r, m, a, id);
    #1;
    chk("pend_out",  32'(bus.pend_out),  32'(mshow));
    chk("irq_valid", 32'(bus.irq_valid), 32'(mvalid));
    chk("pending",   32'(bus.pending),   32'(mp));
    chk("drop_cnt",  32'(bus.drop_cnt),  32'(mdrop));
    chk("bad_ack",   32'(bus.bad_ack),   32'(mbad));
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      logic [2:0] lo;
      lo = 0;
      for (int b = 7; b >= 0; b--) if (mshow[b]) lo = 3'(b);
      if (mvalid) cycle(8'h00, 8'h00, 1'b1, lo);
      else        cycle(8'h00, 8'h00, 1'b0, 3'd0);
    end
  endtask

  initial begin
    logic [7:0] rr, mm;
    logic       aa;
    logic [2:0] ii;

    // 1: reset
    rst = 1'b1;
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    rst = 1'b0;
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    chk("t1_pend_out", 32'(bus.pend_out), 32'h0);
    chk("t1_valid",    32'(bus.irq_valid), 32'h0);
    chk("t1_pending",  32'(bus.pending), 32'h0);
    chk("t1_drop",     32'(bus.drop_cnt), 32'h0);

    // 2: two lines, ack the higher one, remaining one re-asserts
    cycle(8'h24, 8'h00, 1'b0, 3'd0);
    chk("t2_valid_t1", 32'(bus.irq_valid), 32'h0);
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    chk("t2_pend_out", 32'(bus.pend_out), 32'h24);
    chk("t2_valid",    32'(bus.irq_valid), 32'h1);
    cycle(8'h00, 8'h00, 1'b1, 3'd5);
    chk("t2_pending",  32'(bus.pending), 32'h04);
    chk("t2_valid_lo", 32'(bus.irq_valid), 32'h0);
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    chk("t2_gap",      32'(bus.irq_valid), 32'h0);
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    chk("t2_reassert", 32'(bus.pend_out), 32'h04);
    drain();

    // 3: masked line stays pending and shows once unmasked
    cycle(8'h81, 8'h80, 1'b0, 3'd0);
    cycle(8'h00, 8'h80, 1'b0, 3'd0);
    chk("t3_masked", 32'(bus.pend_out), 32'h01);
    cycle(8'h00, 8'h80, 1'b1, 3'd0);
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    chk("t3_unmasked", 32'(bus.pend_out), 32'h80);
    drain();

    // 4: ack id not in snapshot
    cycle(8'h02, 8'h00, 1'b0, 3'd0);
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    cycle(8'h00, 8'h00, 1'b1, 3'd6);
    chk("t4_bad",      32'(bus.bad_ack), 32'h1);
    chk("t4_pend_out", 32'(bus.pend_out), 32'h02);
    chk("t4_pending",  32'(bus.pending), 32'h02);
    drain();

`ifdef IRQ_EDGE_DETECT_EN
    // 5: repeated edges on a pending line, then ack racing a new edge
    cycle(8'h08, 8'h00, 1'b0, 3'd0);
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    cycle(8'h08, 8'h00, 1'b0, 3'd0);
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    cycle(8'h08, 8'h00, 1'b0, 3'd0);
    chk("t5_drop", 32'(bus.drop_cnt), 32'd2);
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    cycle(8'h08, 8'h00, 1'b1, 3'd3);
    chk("t5_set_wins", 32'(bus.pending[3]), 32'h1);
    drain();
`else
    // level mode: held line re-pends right after its ack
    cycle(8'h10, 8'h00, 1'b0, 3'd0);
    cycle(8'h10, 8'h00, 1'b0, 3'd0);
    cycle(8'h10, 8'h00, 1'b1, 3'd4);
    chk("lv_pending", 32'(bus.pending), 32'h10);
    cycle(8'h10, 8'h00, 1'b0, 3'd0);
    cycle(8'h10, 8'h00, 1'b0, 3'd0);
    chk("lv_reassert", 32'(bus.pend_out), 32'h10);
    drain();
`endif

    // 6: reset in ASSERT wipes everything, including sticky state
    cycle(8'h01, 8'h00, 1'b0, 3'd0);
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    chk("t6_pre_valid", 32'(bus.irq_valid), 32'h1);
    rst = 1'b1;
    cycle(8'h00, 8'h00, 1'b0, 3'd0);
    rst = 1'b0;
    chk("t6_pend_out", 32'(bus.pend_out), 32'h0);
    chk("t6_valid",    32'(bus.irq_valid), 32'h0);
    chk("t6_pending",  32'(bus.pending), 32'h0);
    chk("t6_drop",     32'(bus.drop_cnt), 32'h0);
    chk("t6_bad",      32'(bus.bad_ack), 32'h0);

    // random traffic against the model
    mm = 8'h00;
    for (int n = 0; n < 600; n++) begin
      rr = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 9) == 0) mm = 8'($urandom) & 8'($urandom);
      aa = ($urandom_range(0, 2) == 0);
      ii = 3'($urandom_range(0, 7));
      if (mvalid && $urandom_range(0, 4) != 0) begin
        for (int t = 0; t < 16; t++) begin
          if (mshow[ii]) break;
          ii = 3'($urandom_range(0, 7));
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle(rr, mm, aa, ii);
    end
    rst = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
